// File: rtl/seq_checker_pkg.sv
// Shared types and default parameters for the count-stream sequence checker.
package seq_checker_pkg;

  // Checker phases: find a base value, follow the stream, stall once after an error
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    RESYNC = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ERR_W  = 16;
  localparam int DEF_LOCK_N = 4;

  // Width of the run-length counter; wide enough for any LOCK_N in 1..255
  localparam int MATCH_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// clr and inc together restart the count at 1, so a new run can begin
// with its first event counted in the same cycle.
module sat_counter
  import seq_checker_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Count events, holding at LIMIT; clear (or restart) wins over a plain increment
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? ONE : '0;
    end else if (inc && (count < LIMIT)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/seq_checker.sv
// Checks that an incoming count stream increments by one (mod 2^WIDTH),
// reporting lock, per-error pulses and a saturating error total.
module seq_checker
  import seq_checker_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ERR_W  = DEF_ERR_W,
  parameter int LOCK_N = DEF_LOCK_N
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] last_value
);

  localparam logic [WIDTH-1:0]   ONE      = WIDTH'(1);
  localparam logic [MATCH_W-1:0] LOCK_LIM = MATCH_W'(LOCK_N);
  // match_cnt value before the increment that completes a lock
  localparam logic [MATCH_W-1:0] LOCK_M1  = MATCH_W'(LOCK_N - 1);
  localparam logic               LOCK_ON_SYNC = (LOCK_N == 1);

  state_t             state;
  logic [WIDTH-1:0]   expected;
  logic [MATCH_W-1:0] match_cnt;

  logic accept;
  logic is_match;
  logic err_hit;
  logic m_inc;
  logic m_clr;

  // Only the post-error stall refuses data; independent of in_valid
  assign in_ready = (state != RESYNC);
  assign accept   = in_valid && in_ready;
  assign is_match = (in_data == expected);

  // A transfer coinciding with clear is swallowed, so it never counts as an error
  assign err_hit = accept && !clear && (state == CHECK) && !is_match;

  // Run length: restart at 1 on the sync value, bump on each match, zero on error/clear
  assign m_inc = accept && !clear && ((state == HUNT) || ((state == CHECK) && is_match));
  assign m_clr = clear || err_hit || (accept && (state == HUNT));

  sat_counter #(
    .WIDTH (MATCH_W),
    .LIMIT (LOCK_LIM)
  ) u_match_cnt (
    .clock (clock),
    .rst_n (rst_n),
    .inc   (m_inc),
    .clr   (m_clr),
    .count (match_cnt)
  );

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .clock (clock),
    .rst_n (rst_n),
    .inc   (err_hit),
    .clr   (clear),
    .count (err_count)
  );

  // Sequence FSM plus the expected/last_value registers and registered flags
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      expected   <= '0;
      last_value <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (clear) begin
        state  <= HUNT;
        locked <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            if (accept) begin
              expected   <= in_data + ONE;
              last_value <= in_data;
              locked     <= LOCK_ON_SYNC;
              state      <= CHECK;
            end
          end
          CHECK: begin
            if (accept) begin
              last_value <= in_data;
              if (is_match) begin
                expected <= in_data + ONE;
                if (match_cnt >= LOCK_M1) locked <= 1'b1;
              end else begin
                err_pulse <= 1'b1;
                locked    <= 1'b0;
                state     <= RESYNC;
              end
            end
          end
          RESYNC:  state <= HUNT;
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
// Randomised scoreboard bench for seq_checker: a stream-level reference model
// predicts each post-edge output snapshot; a monitor pops and compares.
module tb_seq_checker;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       clear = 1'b0;

  logic        rdy_a, lk_a, pl_a;
  logic [15:0] ec_a;
  logic [7:0]  lv_a;
  logic        rdy_b, lk_b, pl_b;
  logic [1:0]  ec_b;
  logic [7:0]  lv_b;

  always #5 clock = ~clock;

  seq_checker #(.WIDTH(8), .ERR_W(16), .LOCK_N(4)) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_a), .clear(clear), .locked(lk_a), .err_pulse(pl_a),
    .err_count(ec_a), .last_value(lv_a)
  );

  seq_checker #(.WIDTH(8), .ERR_W(2), .LOCK_N(4)) dut_sat (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_b), .clear(clear), .locked(lk_b), .err_pulse(pl_b),
    .err_count(ec_b), .last_value(lv_b)
  );

  typedef struct {
    bit         rdy;
    bit         lk;
    bit         pl;
    int         errs;
    logic [7:0] last;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: stream-level view (base found? value wanted next, run length)
  bit         m_synced, m_stall, m_pulse;
  int         m_run, m_errs;
  logic [7:0] m_next, m_last;

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_synced = 0; m_stall = 0; m_pulse = 0;
    m_run = 0; m_errs = 0; m_next = 8'h00; m_last = 8'h00;
  endtask

  // One cycle: drive inputs, advance the model across the next edge, queue the prediction
  task automatic step(input bit v, input logic [7:0] d, input bit c);
    bit   acc;
    exp_t e;
    @(posedge clock); #2;
    in_valid = v; in_data = d; clear = c;
    acc = v && !m_stall;
    m_pulse = 0;
    if (c) begin
      m_errs = 0; m_run = 0; m_synced = 0; m_stall = 0;
    end else if (m_stall) begin
      m_stall = 0;
    end else if (acc) begin
      m_last = d;
      if (!m_synced) begin
        m_synced = 1; m_run = 1; m_next = 8'(d + 8'd1);
      end else if (d == m_next) begin
        m_run++; m_next = 8'(d + 8'd1);
      end else begin
        m_pulse = 1; m_errs++; m_run = 0; m_synced = 0; m_stall = 1;
      end
    end
    e.rdy = !m_stall; e.lk = (m_run >= 4); e.pl = m_pulse;
    e.errs = m_errs; e.last = m_last;
    q.push_back(e);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock
  task automatic async_reset();
    @(posedge clock); #2;
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
    #1;
    chk("rst_ready", int'(rdy_a), 1);
    chk("rst_locked", int'(lk_a), 0);
    chk("rst_pulse", int'(pl_a), 0);
    chk("rst_errcnt", int'(ec_a), 0);
    chk("rst_errcnt_sat", int'(ec_b), 0);
    chk("rst_last", int'(lv_a), 0);
    model_reset();
    q.delete();
    @(posedge clock); @(posedge clock); #2;
    rst_n = 1'b1;
  endtask

  // Monitor: just after each edge, compare DUT outputs with the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clock); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("in_ready", int'(rdy_a), int'(e.rdy));
        chk("locked", int'(lk_a), int'(e.lk));
        chk("err_pulse", int'(pl_a), int'(e.pl));
        chk("err_count", int'(ec_a), sat(e.errs, 65535));
        chk("last_value", int'(lv_a), int'(e.last));
        chk("sat_err_count", int'(ec_b), sat(e.errs, 3));
        chk("sat_locked", int'(lk_b), int'(e.lk));
      end
    end
  end

  initial begin
    bit         v, c;
    logic [7:0] d;
    model_reset();
    async_reset();
    step(0, 8'h00, 0);                      // reset state seen through a clock edge

    // Sync and lock
    for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0);
    step(0, 8'h00, 0);

    // Wrap through FF -> 00
    step(0, 8'h00, 1);
    for (int i = 0; i < 6; i++) step(1, 8'(8'hFC + i), 0);

    // Mismatch, one stall cycle (valid held during it), resync and relock
    step(0, 8'h00, 1);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h1D + i), 0);
    step(1, 8'h22, 0);
    step(1, 8'h40, 0);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0);

    // Five errors: narrow counter must stick at 3
    for (int i = 0; i < 5; i++) begin
      step(1, 8'(8'h50 + 16 * i), 0);
      step(1, 8'(8'h55 + 16 * i), 0);
      step(0, 8'h00, 0);
    end

    // clear beats a matching transfer in the same cycle
    for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 0);
    step(1, 8'h64, 1);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h70 + i), 0);

    // Random stream: gaps, occasional bad values and clears, one mid-stream reset
    for (int n = 0; n < 800; n++) begin
      if (n == 400) async_reset();
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 59) == 0);
      if (!m_synced || $urandom_range(0, 11) == 0) d = 8'($urandom);
      else d = m_next;
      step(v, d, c);
    end

    step(0, 8'h00, 0);
    @(posedge clock); #3;
    if (q.size() != 0) chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
